decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Registered, back-pressured decode stage with a register-write scoreboard. It accepts one MIPS instruction per cycle from fetch, latches it, and produces a compact control vector and destination index. It interlocks on read-after-write hazards against writes still in flight, and holds the instruction until the hazard clears. It sits between fetch and execute and supersedes purely combinational decode: it adds pipelining, a ready/valid handshake, flush, and a parametrised write-back distance.

## Interface
Parameters:
- NUM_REGS, 32: architectural register count; index width RI_W = clog2(NUM_REGS).
- WB_DELAY, 3: cycles from issue until the written value is readable by a dependent instruction (1..15).
- PC_W, 32: program-counter width.
- STALL_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  fetch presents insn/pc.
- in_ready  out  1  stage can accept this cycle.
- insn  in  32  instruction word.
- pc  in  PC_W  instruction address.
- flush  in  1  discard the held instruction (branch redirect).
- out_valid  out  1  held instruction is hazard-free and offered to execute.
- out_ready  in  1  execute accepts.
- out_insn  out  32  held instruction.
- out_pc  out  PC_W  held pc.
- out_ctrl  out  11  control vector.
- out_dest  out  RI_W  destination register index.
- stall_cycles  out  STALL_W  saturating count of hazard-stalled cycles.

## Operation
- out_ctrl bit assignments: [0] RWE, [1] SRC1 (reads rs), [2] SRC2 (reads rt), [3] RDST (dest=rd), [4] ALUINB (immediate), [5] LOAD, [6] STORE, [7] BR, [8] JP, [9] RA (link), [10] ILLEGAL.
- Decode classes:
  - R-type three-register ALU (ADD/ADDU/SUB/SUBU/SLT/SLTU/AND/OR/XOR/NOR/SLLV/SRLV/SRAV) and MUL (opcode 011100): RWE, SRC1, SRC2, RDST.
  - SLL/SRL/SRA: RWE, SRC2, RDST.
  - MFHI/MFLO: RWE, RDST.
  - DIV/DIVU: SRC1, SRC2.
  - JR: JP, SRC1.
  - JALR: JP, RWE, RDST, SRC1.
  - ADDIU/SLTI/SLTIU/ORI/XORI: RWE, SRC1, ALUINB.
  - LUI: RWE, ALUINB.
  - LW/LB/LBU: RWE, SRC1, ALUINB, LOAD.
  - SW/SB: SRC1, SRC2, ALUINB, STORE.
  - BEQ/BNE: BR, SRC1, SRC2.
  - REGIMM/BGTZ/BLEZ: BR, SRC1.
  - J: JP.
  - JAL: JP, RA, RWE.
- insn==0 (NOP): out_ctrl all zero. Unlisted opcode or funct: only ILLEGAL set; the instruction still flows, and ILLEGAL never sets RWE.
- out_dest: 31 if RA; else rd if RDST; else rt. When RWE=0, out_dest=0.
- Scoreboard: one counter per register, width clog2(WB_DELAY+1).
  - Each cycle, every nonzero counter decrements by 1.
  - On issue with RWE=1 and out_dest≠0, the counter for out_dest loads WB_DELAY. The load overrides the decrement in the same cycle.
  - Register 0 is never marked pending.
- hazard = held_valid and ((SRC1 and rs≠0 and cnt[rs]≠0) or (SRC2 and rt≠0 and cnt[rt]≠0)). It is evaluated on current counter values, before this cycle's update.
- Handshake signals:
  - out_valid = held_valid and !hazard.
  - issue = out_valid and out_ready.
  - in_ready = rst_n and !flush and (!held_valid or issue).
  - Accept = in_valid and in_ready; it loads the hold register and sets held_valid.
- Issue without accept clears held_valid. Issue and accept in the same cycle replaces the held instruction, giving 1 instruction per cycle.
- Flush clears held_valid and blocks accept for that cycle. It does not touch the scoreboard, because writes already issued still complete.
- stall_cycles increments each cycle held_valid and hazard is true, and saturates at all-ones.

## Timing
- Reset values: held_valid=0, out_valid=0, in_ready=0 while rst_n=0, then 1. out_insn=0, out_pc=0, out_ctrl=0, out_dest=0, all counters 0, stall_cycles=0.
- Latency: accepted at edge t, out_valid high in cycle t+1 if no hazard.
- Dependent back-to-back pair: producer issues at cycle t; the consumer's out_valid is low for cycles t+1..t+WB_DELAY and high at t+WB_DELAY+1.
- out_ready low with out_valid high: insn, pc, ctrl and dest are held stable, and in_ready stays low.
- Reset mid-hazard: the held instruction is dropped and all counters clear in the same edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0, stall_cycles=0.
- Streaming: 8 independent ADDIU (rs=0, rt=1..8) with out_ready=1 -> 8 issues on consecutive cycles, out_ctrl=0x013, out_dest=rt, stall_cycles=0.
- RAW interlock, WB_DELAY=3: ADDU r3,r1,r2 then ADDU r4,r3,r3 -> second is held 3 cycles, issues on the 4th, stall_cycles=3.
- Dest r0 and link: ADDIU r0 then a reader of r0 -> no stall. JAL -> out_dest=31, out_ctrl=0x301; a following JR r31 stalls WB_DELAY cycles.
- Backpressure: out_ready=0 for 5 cycles on a held LW -> outputs stable, in_ready=0, no scoreboard load until issue.
- Flush: assert flush during a stalled consumer -> held_valid=0 next cycle, pending counters keep decrementing, insn presented in the flush cycle is not accepted.

Source files
------------

// File: rtl/decode_issue_stage.sv
`default_nettype none
// decode_issue_stage -- registered MIPS decode/issue with ready/valid handshake
// and a per-register write-back scoreboard that interlocks RAW hazards. Rev 1.0
module decode_issue_stage #(
  parameter  int NUM_REGS = 32,
  parameter  int WB_DELAY = 3,
  parameter  int PC_W     = 32,
  parameter  int STALL_W  = 16,
  localparam int RI_W     = $clog2(NUM_REGS),
  localparam int CNT_W    = $clog2(WB_DELAY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        insn,
  input  logic [PC_W-1:0]    pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_insn,
  output logic [PC_W-1:0]    out_pc,
  output logic [10:0]        out_ctrl,
  output logic [RI_W-1:0]    out_dest,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int B_RWE    = 0;
  localparam int B_SRC1   = 1;
  localparam int B_SRC2   = 2;
  localparam int B_RDST   = 3;
  localparam int B_ALUINB = 4;
  localparam int B_LOAD   = 5;
  localparam int B_STORE  = 6;
  localparam int B_BR     = 7;
  localparam int B_JP     = 8;
  localparam int B_RA     = 9;
  localparam int B_ILL    = 10;

  localparam logic [10:0] M_RWE    = 11'(1) << B_RWE;
  localparam logic [10:0] M_SRC1   = 11'(1) << B_SRC1;
  localparam logic [10:0] M_SRC2   = 11'(1) << B_SRC2;
  localparam logic [10:0] M_RDST   = 11'(1) << B_RDST;
  localparam logic [10:0] M_ALUINB = 11'(1) << B_ALUINB;
  localparam logic [10:0] M_LOAD   = 11'(1) << B_LOAD;
  localparam logic [10:0] M_STORE  = 11'(1) << B_STORE;
  localparam logic [10:0] M_BR     = 11'(1) << B_BR;
  localparam logic [10:0] M_JP     = 11'(1) << B_JP;
  localparam logic [10:0] M_RA     = 11'(1) << B_RA;
  localparam logic [10:0] M_ILL    = 11'(1) << B_ILL;

  localparam logic [10:0] CLS_ALU3  = M_RWE | M_SRC1 | M_SRC2 | M_RDST;
  localparam logic [10:0] CLS_SHIFT = M_RWE | M_SRC2 | M_RDST;
  localparam logic [10:0] CLS_MFHL  = M_RWE | M_RDST;
  localparam logic [10:0] CLS_DIV   = M_SRC1 | M_SRC2;
  localparam logic [10:0] CLS_JR    = M_JP | M_SRC1;
  localparam logic [10:0] CLS_JALR  = M_JP | M_RWE | M_RDST | M_SRC1;
  localparam logic [10:0] CLS_ALUI  = M_RWE | M_SRC1 | M_ALUINB;
  localparam logic [10:0] CLS_LUI   = M_RWE | M_ALUINB;
  localparam logic [10:0] CLS_LOAD  = M_RWE | M_SRC1 | M_ALUINB | M_LOAD;
  localparam logic [10:0] CLS_STORE = M_SRC1 | M_SRC2 | M_ALUINB | M_STORE;
  localparam logic [10:0] CLS_BR2   = M_BR | M_SRC1 | M_SRC2;
  localparam logic [10:0] CLS_BR1   = M_BR | M_SRC1;
  localparam logic [10:0] CLS_JAL   = M_JP | M_RA | M_RWE;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_MUL     = 6'h1C;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [RI_W-1:0] LINK_REG = RI_W'(31);

  logic [10:0]      dec_ctrl;
  logic [RI_W-1:0]  dec_dest;
  logic             held_valid;
  logic [CNT_W-1:0] sb_cnt [NUM_REGS];
  logic [RI_W-1:0]  rs_idx;
  logic [RI_W-1:0]  rt_idx;
  logic             rs_busy;
  logic             rt_busy;
  logic             hazard;
  logic             issue;
  logic             accept;

  // Decode the incoming word so the hold register carries ready-made control.
  always_comb begin
    dec_ctrl = '0;
    dec_dest = '0;
    if (insn != 32'd0) begin
      case (insn[31:26])
        OP_SPECIAL: begin
          case (insn[5:0])
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLT, FN_SLTU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLLV, FN_SRLV, FN_SRAV:  dec_ctrl = CLS_ALU3;
            FN_SLL, FN_SRL, FN_SRA:     dec_ctrl = CLS_SHIFT;
            FN_MFHI, FN_MFLO:           dec_ctrl = CLS_MFHL;
            FN_DIV, FN_DIVU:            dec_ctrl = CLS_DIV;
            FN_JR:                      dec_ctrl = CLS_JR;
            FN_JALR:                    dec_ctrl = CLS_JALR;
            default:                    dec_ctrl = M_ILL;
          endcase
        end
        OP_MUL:                                     dec_ctrl = CLS_ALU3;
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI: dec_ctrl = CLS_ALUI;
        OP_LUI:                                     dec_ctrl = CLS_LUI;
        OP_LW, OP_LB, OP_LBU:                       dec_ctrl = CLS_LOAD;
        OP_SW, OP_SB:                               dec_ctrl = CLS_STORE;
        OP_BEQ, OP_BNE:                             dec_ctrl = CLS_BR2;
        OP_REGIMM, OP_BGTZ, OP_BLEZ:                dec_ctrl = CLS_BR1;
        OP_J:                                       dec_ctrl = M_JP;
        OP_JAL:                                     dec_ctrl = CLS_JAL;
        default:                                    dec_ctrl = M_ILL;
      endcase
    end
    if (dec_ctrl[B_RWE]) begin
      if (dec_ctrl[B_RA])
        dec_dest = LINK_REG;
      else if (dec_ctrl[B_RDST])
        dec_dest = insn[11 +: RI_W];
      else
        dec_dest = insn[16 +: RI_W];
    end
  end

  assign rs_idx = out_insn[21 +: RI_W];
  assign rt_idx = out_insn[16 +: RI_W];

  // Register 0 is never loaded, but the index test keeps r0 reads hazard-free
  // even if a counter were ever nonzero.
  assign rs_busy = out_ctrl[B_SRC1] && (rs_idx != '0) && (sb_cnt[rs_idx] != '0);
  assign rt_busy = out_ctrl[B_SRC2] && (rt_idx != '0) && (sb_cnt[rt_idx] != '0);
  assign hazard  = held_valid && (rs_busy || rt_busy);

  assign out_valid = rst_n && held_valid && !hazard;
  assign issue     = out_valid && out_ready;
  assign in_ready  = rst_n && !flush && (!held_valid || issue);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      out_insn   <= '0;
      out_pc     <= '0;
      out_ctrl   <= '0;
      out_dest   <= '0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (accept) begin
      held_valid <= 1'b1;
      out_insn   <= insn;
      out_pc     <= pc;
      out_ctrl   <= dec_ctrl;
      out_dest   <= dec_dest;
    end else if (issue) begin
      held_valid <= 1'b0;
    end
  end

  // A fresh load on issue wins over the per-cycle countdown.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (!rst_n)
        sb_cnt[r] <= '0;
      else if (issue && out_ctrl[B_RWE] && (r != 0) && (out_dest == RI_W'(r)))
        sb_cnt[r] <= CNT_W'(WB_DELAY);
      else if (sb_cnt[r] != '0)
        sb_cnt[r] <= sb_cnt[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (hazard && (stall_cycles != '1))
      stall_cycles <= stall_cycles + STALL_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// Bench for decode_issue_stage: decode vector table, directed handshake
// sequences and a randomized run against a timestamp scoreboard model.
module tb_decode_issue_stage;

  localparam int NUM_REGS = 32;
  localparam int WB_DELAY = 3;
  localparam int PC_W     = 32;
  localparam int STALL_W  = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        insn;
  logic [PC_W-1:0]    pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_insn;
  logic [PC_W-1:0]    out_pc;
  logic [10:0]        out_ctrl;
  logic [4:0]         out_dest;
  logic [STALL_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  decode_issue_stage #(
    .NUM_REGS(NUM_REGS), .WB_DELAY(WB_DELAY), .PC_W(PC_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .insn(insn), .pc(pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_dest(out_dest), .stall_cycles(stall_cycles)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Control vector straight from the instruction-class list.
  function automatic logic [10:0] ref_ctrl(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic rwe, s1, s2, rdst, imm, ld, st, br, jp, ra, ill;
    op = w[31:26];
    fn = w[5:0];
    {rwe, s1, s2, rdst, imm, ld, st, br, jp, ra, ill} = '0;
    if (w == 32'd0) return 11'd0;
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25,
                     6'h26, 6'h27, 6'h04, 6'h06, 6'h07}) {rwe, s1, s2, rdst} = 4'hF;
      else if (fn inside {6'h00, 6'h02, 6'h03}) {rwe, s2, rdst} = 3'h7;
      else if (fn inside {6'h10, 6'h12}) {rwe, rdst} = 2'h3;
      else if (fn inside {6'h1A, 6'h1B}) {s1, s2} = 2'h3;
      else if (fn == 6'h08) {jp, s1} = 2'h3;
      else if (fn == 6'h09) {jp, rwe, rdst, s1} = 4'hF;
      else ill = 1'b1;
    end
    else if (op == 6'h1C) {rwe, s1, s2, rdst} = 4'hF;
    else if (op inside {6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0E}) {rwe, s1, imm} = 3'h7;
    else if (op == 6'h0F) {rwe, imm} = 2'h3;
    else if (op inside {6'h23, 6'h20, 6'h24}) {rwe, s1, imm, ld} = 4'hF;
    else if (op inside {6'h2B, 6'h28}) {s1, s2, imm, st} = 4'hF;
    else if (op inside {6'h04, 6'h05}) {br, s1, s2} = 3'h7;
    else if (op inside {6'h01, 6'h07, 6'h06}) {br, s1} = 2'h3;
    else if (op == 6'h02) jp = 1'b1;
    else if (op == 6'h03) {jp, ra, rwe} = 3'h7;
    else ill = 1'b1;
    return {ill, ra, jp, br, st, ld, imm, rdst, s2, s1, rwe};
  endfunction

  function automatic logic [4:0] ref_dest(input logic [31:0] w, input logic [10:0] c);
    if (!c[0]) return 5'd0;
    if (c[9]) return 5'd31;
    if (c[3]) return w[15:11];
    return w[20:16];
  endfunction

  // Model: a write issued in cycle t becomes readable from cycle t+WB_DELAY+1.
  bit          m_hv;
  bit          m_in_rst;
  bit          m_known;
  logic [31:0] m_insn;
  logic [31:0] m_pc;
  longint      ready_at [NUM_REGS];
  int          m_stall;
  longint      cyc;

  logic        s_ov, s_ir;
  logic [31:0] s_insn;
  logic [10:0] s_ctrl;
  logic [4:0]  s_dest;
  logic [STALL_W-1:0] s_stall;
  int          dut_iss;

  function automatic bit m_hazard();
    logic [10:0] c;
    int rs, rt;
    c  = ref_ctrl(m_insn);
    rs = int'(m_insn[25:21]);
    rt = int'(m_insn[20:16]);
    return m_hv && ((c[1] && rs != 0 && cyc < ready_at[rs]) ||
                    (c[2] && rt != 0 && cyc < ready_at[rt]));
  endfunction

  task automatic step(input bit rn, input bit iv, input logic [31:0] ins,
                      input logic [31:0] p, input bit fl, input bit orr);
    bit haz, ov, ir, iss;
    logic [10:0] c;
    logic [4:0]  d;
    rst_n = rn; in_valid = iv; insn = ins; pc = p; flush = fl; out_ready = orr;
    #4;
    haz = m_hazard();
    ov  = rn && m_hv && !haz;
    iss = ov && orr;
    ir  = rn && !fl && (!m_hv || iss);
    s_ov = out_valid; s_ir = in_ready; s_insn = out_insn;
    s_ctrl = out_ctrl; s_dest = out_dest; s_stall = stall_cycles;
    if (out_valid === 1'b1 && orr) dut_iss++;
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("in_ready", 64'(in_ready), 64'(ir));
    if (m_known) chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    if (!rn && m_in_rst) begin
      chk("rst_out_insn", 64'(out_insn), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_out_dest", 64'(out_dest), 64'd0);
    end else if (m_known && m_hv) begin
      c = ref_ctrl(m_insn);
      chk("out_insn", 64'(out_insn), 64'(m_insn));
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_ctrl", 64'(out_ctrl), 64'(c));
      chk("out_dest", 64'(out_dest), 64'(ref_dest(m_insn, c)));
    end
    @(posedge clk);
    if (!rn) begin
      m_hv = 0; m_insn = '0; m_pc = '0; m_stall = 0;
      foreach (ready_at[i]) ready_at[i] = 0;
      m_in_rst = 1; m_known = 1;
    end else begin
      m_in_rst = 0;
      if (haz && m_stall < (1 << STALL_W) - 1) m_stall++;
      if (iss) begin
        c = ref_ctrl(m_insn);
        d = ref_dest(m_insn, c);
        if (c[0] && d != 5'd0) ready_at[d] = cyc + WB_DELAY + 1;
      end
      if (fl) m_hv = 0;
      else if (iv && ir) begin m_hv = 1; m_insn = ins; m_pc = p; end
      else if (iss) m_hv = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 32'd0, 32'd0, 0, 1);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(0, 1, i_ins(6'h09, 1, 2, 16'h7), 32'h40, 0, 1);
  endtask

  // Counts the cycles the held instruction waits before it is offered.
  task automatic wait_issue(output int w);
    bit done;
    done = 0;
    w = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      step(1, 0, 32'd0, 32'd0, 0, 1);
      if (s_ov === 1'b1) done = 1;
      else w++;
    end
  endtask

  function automatic logic [31:0] rand_insn();
    int k, a, b, d;
    k = $urandom_range(0, 10);
    a = $urandom_range(0, 7);
    b = $urandom_range(0, 7);
    d = $urandom_range(0, 7);
    case (k)
      0: return r_ins(a, b, d, 0, 6'h21);
      1: return r_ins(a, b, d, 0, 6'h2A);
      2: return i_ins(6'h09, a, b, 16'($urandom));
      3: return i_ins(6'h23, a, b, 16'($urandom));
      4: return i_ins(6'h2B, a, b, 16'($urandom));
      5: return i_ins(6'h04, a, b, 16'($urandom));
      6: return j_ins(6'h03, 26'($urandom));
      7: return r_ins(a, 0, 0, 0, 6'h08);
      8: return r_ins(0, b, d, $urandom_range(0, 31), 6'h00);
      9: return r_ins(a, 0, d, 0, 6'h09);
      default: return 32'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [31:0] insn;
    logic [10:0] ctrl;
    logic [4:0]  dest;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tbl[0]  = '{r_ins(1, 2, 3, 0, 6'h21),          11'h00F, 5'd3};
    tbl[1]  = '{r_ins(0, 6, 5, 2, 6'h00),          11'h00D, 5'd5};
    tbl[2]  = '{r_ins(0, 0, 7, 0, 6'h10),          11'h009, 5'd7};
    tbl[3]  = '{r_ins(1, 2, 0, 0, 6'h1A),          11'h006, 5'd0};
    tbl[4]  = '{r_ins(9, 0, 0, 0, 6'h08),          11'h102, 5'd0};
    tbl[5]  = '{r_ins(9, 0, 10, 0, 6'h09),         11'h10B, 5'd10};
    tbl[6]  = '{{6'h1C, 5'd1, 5'd2, 5'd11, 11'h002}, 11'h00F, 5'd11};
    tbl[7]  = '{i_ins(6'h09, 1, 4, 16'd5),         11'h013, 5'd4};
    tbl[8]  = '{i_ins(6'h0F, 0, 8, 16'h1234),      11'h011, 5'd8};
    tbl[9]  = '{i_ins(6'h23, 2, 12, 16'd0),        11'h033, 5'd12};
    tbl[10] = '{i_ins(6'h2B, 2, 13, 16'd4),        11'h056, 5'd0};
    tbl[11] = '{i_ins(6'h04, 1, 2, 16'h10),        11'h086, 5'd0};
    tbl[12] = '{i_ins(6'h07, 3, 0, 16'h20),        11'h082, 5'd0};
    tbl[13] = '{j_ins(6'h02, 26'h10),              11'h100, 5'd0};
    tbl[14] = '{j_ins(6'h03, 26'h20),              11'h301, 5'd31};
    tbl[15] = '{32'd0,                             11'h000, 5'd0};
    tbl[16] = '{{6'h3F, 26'h123},                  11'h400, 5'd0};
    tbl[17] = '{r_ins(1, 2, 3, 0, 6'h01),          11'h400, 5'd0};
    tbl[18] = '{i_ins(6'h09, 1, 0, 16'd1),         11'h013, 5'd0};

    m_hv = 0; m_in_rst = 0; m_known = 0; m_insn = '0; m_pc = '0;
    m_stall = 0; cyc = 0; dut_iss = 0;
    foreach (ready_at[i]) ready_at[i] = 0;

    // Reset held with fetch asserting valid.
    do_reset(3);
    chk("rst_in_ready", 64'(s_ir), 64'd0);
    chk("rst_stall", 64'(s_stall), 64'd0);

    // Independent ADDIU stream: one issue per cycle.
    dut_iss = 0;
    for (int i = 1; i <= 8; i++) step(1, 1, i_ins(6'h09, 0, i, 16'(i)), 32'(256 + 4 * i), 0, 1);
    step(1, 0, 32'd0, 32'd0, 0, 1);
    chk("stream_ctrl", 64'(s_ctrl), 64'h013);
    chk("stream_dest", 64'(s_dest), 64'd8);
    chk("stream_issues", 64'(dut_iss), 64'd8);
    chk("stream_stall", 64'(s_stall), 64'd0);

    // Back-to-back RAW pair.
    do_reset(1);
    step(1, 1, r_ins(1, 2, 3, 0, 6'h21), 32'h100, 0, 1);
    step(1, 1, r_ins(3, 3, 4, 0, 6'h21), 32'h104, 0, 1);
    wait_issue(w);
    chk("raw_wait", 64'(w), 64'(WB_DELAY));
    chk("raw_stall", 64'(s_stall), 64'(WB_DELAY));

    // r0 destination never interlocks; JAL links r31.
    do_reset(1);
    step(1, 1, i_ins(6'h09, 0, 0, 16'd1), 32'h200, 0, 1);
    step(1, 1, r_ins(0, 0, 5, 0, 6'h21), 32'h204, 0, 1);
    wait_issue(w);
    chk("r0_wait", 64'(w), 64'd0);
    step(1, 1, j_ins(6'h03, 26'h40), 32'h208, 0, 1);
    step(1, 1, r_ins(31, 0, 0, 0, 6'h08), 32'h20C, 0, 1);
    chk("jal_ctrl", 64'(s_ctrl), 64'h301);
    chk("jal_dest", 64'(s_dest), 64'd31);
    wait_issue(w);
    chk("jr_wait", 64'(w), 64'(WB_DELAY));

    // Backpressure on a held LW; scoreboard must load only at issue.
    do_reset(1);
    step(1, 1, i_ins(6'h23, 1, 6, 16'd0), 32'h300, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, r_ins(6, 6, 7, 0, 6'h21), 32'h304, 0, 0);
      chk("bp_in_ready", 64'(s_ir), 64'd0);
      chk("bp_out_valid", 64'(s_ov), 64'd1);
      chk("bp_insn", 64'(s_insn), 64'(i_ins(6'h23, 1, 6, 16'd0)));
    end
    step(1, 1, r_ins(6, 6, 7, 0, 6'h21), 32'h304, 0, 1);
    wait_issue(w);
    chk("bp_reader_wait", 64'(w), 64'(WB_DELAY));

    // Flush a stalled consumer; pending counters keep running down.
    do_reset(1);
    step(1, 1, r_ins(1, 2, 3, 0, 6'h21), 32'h400, 0, 1);
    step(1, 1, r_ins(3, 3, 4, 0, 6'h21), 32'h404, 0, 1);
    step(1, 1, i_ins(6'h09, 0, 9, 16'h55), 32'h408, 1, 1);
    chk("flush_in_ready", 64'(s_ir), 64'd0);
    step(1, 1, r_ins(3, 0, 10, 0, 6'h21), 32'h40C, 0, 1);
    chk("flush_dropped", 64'(s_ov), 64'd0);
    chk("flush_accept_next", 64'(s_ir), 64'd1);
    wait_issue(w);
    chk("flush_sb_kept", 64'(w), 64'(WB_DELAY - 2));

    // Decode table.
    do_reset(1);
    foreach (tbl[i]) begin
      step(1, 1, tbl[i].insn, 32'(4096 + 4 * i), 0, 0);
      step(1, 0, 32'd0, 32'd0, 0, 1);
      chk($sformatf("tbl%0d_ctrl", i), 64'(s_ctrl), 64'(tbl[i].ctrl));
      chk($sformatf("tbl%0d_dest", i), 64'(s_dest), 64'(tbl[i].dest));
      for (int k = 0; k < 12 && m_hv; k++) idle(1);
    end

    // Randomized traffic including flushes and occasional mid-run resets.
    for (int n = 0; n < 2500; n++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), rand_insn(),
           $urandom, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(WB_DELAY + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
